// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Fetch sequencer: one boot cycle, normal running, sticky trap.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // A fetch is legal when it is word aligned and the whole word lies inside memory.
    function automatic logic is_legal_fetch(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] size
    );
        return (addr[1:0] == 2'b00) && (addr <= size - ADDR_W'(4));
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline holding register with load, hold and clear controls.
// clear takes priority over load; with neither asserted the contents hold.
// clear squashes the instruction and its valid bit but keeps the last pc4.
module if_id_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);
    import instruction_fetch_unit_pkg::*;

    // Capture, squash or hold the fetched word and its return address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr <= NOP_WORD;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= NOP_WORD;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the instruction memory address, fills the
// IF/ID register, honours stalls and redirects, and traps illegal fetches.
module instruction_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 100,
    parameter int                IMEM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);
    import instruction_fetch_unit_pkg::*;

    localparam logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(IMEM_BYTES);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fault_next;
    logic [ADDR_W-1:0] fault_pc_next;
    logic              id_load;
    logic              id_clear;

    // The fetch address comes straight from the PC register, so redirect and
    // stall never reach imem_addr combinationally.
    assign imem_addr = pc;
    assign pc_plus4  = pc + ADDR_W'(4);

    // Next-state, next-PC, fault and IF/ID control decode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
        state_next    = state;
        pc_next       = pc;
        fault_next    = fault;
        fault_pc_next = fault_pc;
        id_load       = 1'b0;
        id_clear      = 1'b0;

        unique case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN: begin
                if (redirect) begin
                    // Redirect outranks stall and squashes the wrong-path fetch.
                    id_clear = 1'b1;
                    if (is_legal_fetch(redirect_pc, MEM_SIZE)) begin
                        pc_next = redirect_pc;
                    end else begin
                        fault_next    = 1'b1;
                        fault_pc_next = redirect_pc;
                        state_next    = FAULT;
                    end
                end else if (!stall) begin
                    id_load = 1'b1;
                    if (is_legal_fetch(pc_plus4, MEM_SIZE)) begin
                        pc_next = pc_plus4;
                    end else begin
                        // Top of memory: the last word is still delivered, then trap.
                        fault_next    = 1'b1;
                        fault_pc_next = pc_plus4;
                        state_next    = FAULT;
                    end
                end
            end

            FAULT: begin
                // Frozen until reset; keep IF/ID empty.
                id_clear = 1'b1;
            end

            default: begin
                state_next = FAULT;
                id_clear   = 1'b1;
            end
        endcase
    end

    // State, PC and fault registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fault    <= fault_next;
            fault_pc <= fault_pc_next;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (id_load),
        .clear    (id_clear),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a big-endian
// byte-addressed combinational instruction memory model.
module tb_instruction_fetch_unit;

    localparam int MEM_BYTES = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fault_pc;

    logic [7:0]  mem [0:MEM_BYTES-1];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'd100),
        .IMEM_BYTES (MEM_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    // Combinational big-endian read; out-of-range addresses return zero.
    always_comb begin
        imem_instr = 32'h0;
        if (imem_addr <= 32'(MEM_BYTES - 4))
            imem_instr = {mem[imem_addr], mem[imem_addr + 1],
                          mem[imem_addr + 2], mem[imem_addr + 3]};
    end

    task automatic put_word(input int addr, input logic [31:0] word);
        mem[addr]     = word[31:24];
        mem[addr + 1] = word[23:16];
        mem[addr + 2] = word[15:8];
        mem[addr + 3] = word[7:0];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"},   if_id_pc4,   pc4);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] run_words [6] = '{32'h24130005, 32'h2414000a, 32'h24150003,
                                   32'h24160002, 32'h0e74b820, 32'h0e75c024};

    initial begin
        for (int a = 0; a < MEM_BYTES; a += 4) put_word(a, {16'hdead, 16'(a)});
        put_word(100, 32'h48080000);
        put_word(104, 32'h48090004);
        for (int i = 0; i < 6; i++) put_word(200 + 4 * i, run_words[i]);
        put_word(500, 32'h2413000f);
        put_word(16380, 32'ha0b0c0d0);

        // Reset state and boot.
        do_reset();
        check_id("rst", 32'h0, 32'h0, 1'b0);
        check("rst.fault", 32'(fault), 32'h0);
        check("rst.fault_pc", fault_pc, 32'h0);
        check("rst.imem_addr", imem_addr, 32'd100);
        step();  // BOOT cycle, no capture
        check_id("boot", 32'h0, 32'h0, 1'b0);
        check("boot.imem_addr", imem_addr, 32'd100);
        step();
        check_id("first", 32'h48080000, 32'd104, 1'b1);
        step();
        check_id("second", 32'h48090004, 32'd108, 1'b1);

        // Straight-line run from 200 with a 3-cycle stall at pc=216.
        redirect = 1'b1; redirect_pc = 32'd200;
        step();
        redirect = 1'b0;
        check_id("redir200", 32'h0, 32'd108, 1'b0);
        check("redir200.imem_addr", imem_addr, 32'd200);
        for (int i = 0; i < 4; i++) begin
            step();
            check_id($sformatf("run%0d", i), run_words[i], 32'(204 + 4 * i), 1'b1);
        end
        check("pre_stall.imem_addr", imem_addr, 32'd216);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.imem_addr", imem_addr, 32'd216);
            check_id($sformatf("stall%0d", i), 32'h24160002, 32'd216, 1'b1);
        end
        stall = 1'b0;
        for (int i = 4; i < 6; i++) begin
            step();
            check_id($sformatf("run%0d", i), run_words[i], 32'(204 + 4 * i), 1'b1);
        end

        // Redirect wins over a simultaneous stall.
        redirect = 1'b1; redirect_pc = 32'd520;
        step();
        redirect_pc = 32'd500; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("rs.imem_addr", imem_addr, 32'd500);
        check("rs.valid", 32'(if_id_valid), 32'h0);
        check("rs.instr", if_id_instr, 32'h0);
        step();
        check_id("after_rs", 32'h2413000f, 32'd504, 1'b1);

        // Illegal (misaligned) redirect traps; further stimulus ignored.
        redirect = 1'b1; redirect_pc = 32'd502;
        step();
        check("ill.fault", 32'(fault), 32'h1);
        check("ill.fault_pc", fault_pc, 32'd502);
        check("ill.valid", 32'(if_id_valid), 32'h0);
        check("ill.imem_addr", imem_addr, 32'd504);
        redirect_pc = 32'd200;
        step();
        redirect = 1'b0;
        step();
        check("frozen.imem_addr", imem_addr, 32'd504);
        check("frozen.fault_pc", fault_pc, 32'd502);
        check("frozen.fault", 32'(fault), 32'h1);
        check("frozen.valid", 32'(if_id_valid), 32'h0);
        do_reset();
        check("rst2.imem_addr", imem_addr, 32'd100);
        check("rst2.fault", 32'(fault), 32'h0);
        check("rst2.fault_pc", fault_pc, 32'h0);

        // Redirect just past the last legal word is illegal.
        step();  // BOOT
        redirect = 1'b1; redirect_pc = 32'd16384;
        step();
        redirect = 1'b0;
        check("oob.fault", 32'(fault), 32'h1);
        check("oob.fault_pc", fault_pc, 32'd16384);
        check("oob.imem_addr", imem_addr, 32'd100);

        // Sequential run-off at the top of memory.
        do_reset();
        step();  // BOOT
        redirect = 1'b1; redirect_pc = 32'd16380;
        step();
        redirect = 1'b0;
        check("top.imem_addr", imem_addr, 32'd16380);
        check("top.fault", 32'(fault), 32'h0);
        step();
        check_id("runoff", 32'ha0b0c0d0, 32'd16384, 1'b1);
        check("runoff.fault", 32'(fault), 32'h1);
        check("runoff.fault_pc", fault_pc, 32'd16384);
        step();
        check("runoff.after.valid", 32'(if_id_valid), 32'h0);
        check("runoff.after.imem_addr", imem_addr, 32'd16380);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
